// File: rtl/ap_bitserial_alu.sv
// ap_bitserial_alu: associative-processor engine computing C = A op B bit-serially over all rows via truth-table compare/write passes.
module ap_bitserial_alu #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_BITS  = $clog2(CELL_QUANT)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [1:0]           sel_col,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [1:0]           op,
  input  logic                 start,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 ap_state_irq
);
  localparam int BW = $clog2(WORD_SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);
  typedef enum logic [2:0] {IDLE, COMPARE, WRITE, ADVANCE, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [2:0] pass_q, pass_d;
  logic [1:0] op_q, op_d;
  logic irq_q, irq_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d, rd_data;
  logic [CELL_QUANT-1:0] cy_q, cy_d, cyn_q, cyn_d, tag_q, tag_d, match;
  logic [CELL_QUANT-1:0][WORD_SIZE-1:0] mem_a_q, mem_b_q, mem_c_q;
  logic is_add, ka, kb, kc, lut_sum, lut_cy, host;
  assign is_add = op_q == 2'd3;
  // key = pass as {a,b} for logic ops, {a,b,cy} for ADD
  assign ka = is_add ? pass_q[2] : pass_q[1];
  assign kb = is_add ? pass_q[1] : pass_q[0];
  assign kc = pass_q[0];
  assign lut_sum = is_add ? ka ^ kb ^ kc : op_q == 2'd0 ? ka | kb : op_q == 2'd1 ? ka & kb : ka ^ kb;
  assign lut_cy = (ka & kb) | (ka & kc) | (kb & kc);
  assign host = state_q == IDLE;
  assign busy = !host;
  assign data_out = dout_q;
  assign ap_state_irq = irq_q;
  assign rd_data = sel_col == 2'd0 ? mem_a_q[addr_in] :
                   sel_col == 2'd1 ? mem_b_q[addr_in] :
                   sel_col == 2'd2 ? mem_c_q[addr_in] : WORD_SIZE'(cy_q[addr_in]);
  assign dout_d = host && read_en ? rd_data : dout_q;
  always_comb begin
    match = '0;
    for (int r = 0; r < CELL_QUANT; r++)
      match[r] = mem_a_q[r][bit_q] == ka && mem_b_q[r][bit_q] == kb && (!is_add || cy_q[r] == kc);
  end
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    pass_d = pass_q;
    op_d = op_q;
    irq_d = irq_q;
    cy_d = cy_q;
    cyn_d = cyn_q;
    tag_d = tag_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = COMPARE;
        op_d = op;
        cy_d = '0;
        cyn_d = '0;
        irq_d = 1'b0;
        bit_d = '0;
        pass_d = '0;
      end
      COMPARE: begin
        tag_d = match;
        state_d = WRITE;
      end
      WRITE: begin
        if (is_add) cyn_d = (cyn_q & ~tag_q) | (tag_q & {CELL_QUANT{lut_cy}});
        if (pass_q == (is_add ? 3'd7 : 3'd3)) state_d = ADVANCE;
        else begin
          pass_d = pass_q + 3'd1;
          state_d = COMPARE;
        end
      end
      ADVANCE: begin
        if (is_add) cy_d = cyn_q;
        pass_d = '0;
        if (bit_q == LAST_BIT) state_d = DONE;
        else begin
          bit_d = bit_q + 1'b1;
          state_d = COMPARE;
        end
      end
      DONE: begin
        irq_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      pass_q <= '0;
      op_q <= '0;
      irq_q <= 1'b0;
      dout_q <= '0;
      cy_q <= '0;
      cyn_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      pass_q <= pass_d;
      op_q <= op_d;
      irq_q <= irq_d;
      dout_q <= dout_d;
      cy_q <= cy_d;
      cyn_q <= cyn_d;
      tag_q <= tag_d;
    end
  end
  // column storage keeps its contents across reset
  always_ff @(posedge CLK100MHZ) begin
    if (host && write_en && sel_col == 2'd0) mem_a_q[addr_in] <= data_in;
    if (host && write_en && sel_col == 2'd1) mem_b_q[addr_in] <= data_in;
    if (host && write_en && sel_col == 2'd2) mem_c_q[addr_in] <= data_in;
    for (int r = 0; r < CELL_QUANT; r++)
      if (state_q == WRITE && tag_q[r]) mem_c_q[r][bit_q] <= lut_sum;
  end
endmodule

// File: tb/tb_ap_bitserial_alu.sv
// tb_ap_bitserial_alu: directed-vector bench for the bit-serial AP ALU.
module tb_ap_bitserial_alu;
  localparam int W = 8;
  localparam int N = 8;
  localparam int AB = $clog2(N);
  logic clk = 1'b0, rst = 1'b0;
  logic [AB-1:0] addr_in = '0;
  logic [W-1:0] data_in = '0, data_out, save;
  logic [1:0] sel_col = '0, op = '0;
  logic write_en = 1'b0, read_en = 1'b0, start = 1'b0, busy, ap_state_irq;
  int checks = 0, errors = 0;
  ap_bitserial_alu #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (
    .CLK100MHZ(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .sel_col(sel_col),
    .write_en(write_en), .read_en(read_en), .op(op), .start(start),
    .data_out(data_out), .busy(busy), .ap_state_irq(ap_state_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] s, input logic [AB-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    sel_col = s;
    addr_in = a;
    data_in = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask
  task automatic expect_rd(input string tag, input logic [1:0] s, input logic [AB-1:0] a, input logic [W-1:0] e);
    @(negedge clk);
    sel_col = s;
    addr_in = a;
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    chk(tag, data_out, e);
  endtask
  task automatic go(input logic [1:0] o);
    @(negedge clk);
    op = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp, input int n0);
    int n = n0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
    chk({tag, "_irq"}, ap_state_irq, 1);
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_dout", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", ap_state_irq, 0);
    @(negedge clk);
    rst = 1'b0;
    wr(0, 5, 8'hA5);
    expect_rd("rd_a5", 0, 5, 8'hA5);
    expect_rd("rst_cy", 3, 0, 8'h00);
    wr(0, 0, 8'hF0);
    wr(1, 0, 8'h0F);
    wr(0, 1, 8'h12);
    wr(1, 1, 8'h21);
    go(0);
    wait_done("or_busy", 73, 0);
    expect_rd("or_c0", 2, 0, 8'hFF);
    expect_rd("or_c1", 2, 1, 8'h33);
    go(1);
    chk("irq_clr", ap_state_irq, 0);
    wait_done("and_busy", 73, 0);
    expect_rd("and_c0", 2, 0, 8'h00);
    expect_rd("and_c1", 2, 1, 8'h00);
    wr(0, 1, 8'h3C);
    wr(1, 1, 8'h0F);
    go(2);
    wait_done("xor_busy", 73, 0);
    expect_rd("xor_c1", 2, 1, 8'h33);
    expect_rd("xor_c0", 2, 0, 8'hFF);
    expect_rd("xor_a1", 0, 1, 8'h3C);
    expect_rd("xor_b1", 1, 1, 8'h0F);
    wr(0, 2, 8'hFF);
    wr(1, 2, 8'h01);
    wr(0, 3, 8'h7F);
    wr(1, 3, 8'h01);
    go(3);
    wait_done("add_busy", 137, 0);
    expect_rd("add_c2", 2, 2, 8'h00);
    expect_rd("add_cy2", 3, 2, 8'h01);
    expect_rd("add_c3", 2, 3, 8'h80);
    expect_rd("add_c0", 2, 0, 8'hFF);
    expect_rd("add_cy3", 3, 3, 8'h00);
    // strobes during busy, plus an op change after acceptance
    go(3);
    save = data_out;
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = 2'd0;
    write_en = 1'b1;
    read_en = 1'b1;
    sel_col = 2'd0;
    addr_in = '0;
    data_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    write_en = 1'b0;
    read_en = 1'b0;
    chk("haz_dout", data_out, save);
    wait_done("haz_busy", 137, 6);
    repeat (2) @(negedge clk);
    chk("haz_norestart", busy, 0);
    expect_rd("haz_a0", 0, 0, 8'hF0);
    expect_rd("haz_c2", 2, 2, 8'h00);
    @(negedge clk);
    op = 2'd3;
    start = 1'b1;
    write_en = 1'b1;
    sel_col = 2'd0;
    addr_in = '0;
    data_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    write_en = 1'b0;
    wait_done("sw_busy", 137, 0);
    expect_rd("sw_c0", 2, 0, 8'h10);
    go(3);
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_irq", ap_state_irq, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_rd("mid_cy2", 3, 2, 8'h00);
    go(3);
    wait_done("fresh_busy", 137, 0);
    expect_rd("fresh_c2", 2, 2, 8'h00);
    expect_rd("fresh_cy2", 3, 2, 8'h01);
    expect_rd("fresh_c3", 2, 3, 8'h80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
